// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and sequencer in front of the single-ported
// data memory. Port 0 is the core load/store unit and port 1 is an auxiliary
// master (debug or DMA loader). A 3-state FSM (IDLE -> ISSUE -> RESP)
// serialises the accesses. Load data is registered back to the port that won.
//
// Request handshake: a requester raises reqN together with a stable payload
// and holds both until it sees gntN. The payload is latched when arbitration
// happens in IDLE. gntN is a one-cycle pulse in ISSUE, and rvalidN is a
// one-cycle pulse in RESP, which occurs only for loads. If a requester drops
// reqN before arbitration, it gets no access. A request that has already been
// latched always completes.
//
// Optional build macro: DMEM_ARB_FIXED_PRIO_EN. When it is defined, port 0
// always wins a tie. When it is undefined, ties are broken round-robin using
// the last winner.
module dmem_arbiter #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // port 0 (core)
   input  logic                  req0,
   input  logic                  we0,
   input  logic [DM_ADDRESS-1:0] addr0,
   input  logic [DATA_W-1:0]     wdata0,
   input  logic [2:0]            funct3_0,
   output logic                  gnt0,
   output logic                  rvalid0,
   output logic [DATA_W-1:0]     rdata0,
   // port 1 (auxiliary)
   input  logic                  req1,
   input  logic                  we1,
   input  logic [DM_ADDRESS-1:0] addr1,
   input  logic [DATA_W-1:0]     wdata1,
   input  logic [2:0]            funct3_1,
   output logic                  gnt1,
   output logic                  rvalid1,
   output logic [DATA_W-1:0]     rdata1,
   // data memory side
   output logic                  MemRead,
   output logic                  MemWrite,
   output logic [DM_ADDRESS-1:0] a,
   output logic [DATA_W-1:0]     wd,
   output logic [2:0]            Funct3,
   input  logic [DATA_W-1:0]     rd,
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t                state_q,     state_d;
   logic                  last_q,      last_d;
   logic                  lat_we_q,    lat_we_d;
   logic                  lat_id_q,    lat_id_d;
   logic                  gnt0_q,      gnt0_d;
   logic                  gnt1_q,      gnt1_d;
   logic                  rvalid0_q,   rvalid0_d;
   logic                  rvalid1_q,   rvalid1_d;
   logic [DATA_W-1:0]     rdata0_q,    rdata0_d;
   logic [DATA_W-1:0]     rdata1_q,    rdata1_d;
   logic                  mem_read_q,  mem_read_d;
   logic                  mem_write_q, mem_write_d;
   logic [DM_ADDRESS-1:0] a_q,         a_d;
   logic [DATA_W-1:0]     wd_q,        wd_d;
   logic [2:0]            funct3_q,    funct3_d;
   logic                  busy_q,      busy_d;

   // Winner of the current arbitration: 0 = port 0, 1 = port 1.
   logic                  win;
   logic                  win_we;

   // Pick the winner among the live requests.
   always_comb begin
      win = 1'b0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
      // Port 0 takes every tie. last_q is not used here.
      if (!req0 && req1) begin
         win = 1'b1;
      end
`else
      // On a tie, the port that did not win last time gets the access.
      if (req0 && req1) begin
         win = ~last_q;
      end else if (req1) begin
         win = 1'b1;
      end
`endif
      win_we = win ? we1 : we0;
   end

   // Next-state and next-output logic for the sequencer.
   // All outputs are registered, so they change on the edge that enters the
   // state where they apply.
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      lat_we_d    = lat_we_q;
      lat_id_d    = lat_id_q;
      gnt0_d      = 1'b0;
      gnt1_d      = 1'b0;
      rvalid0_d   = 1'b0;
      rvalid1_d   = 1'b0;
      rdata0_d    = rdata0_q;
      rdata1_d    = rdata1_q;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      a_d         = a_q;
      wd_d        = wd_q;
      funct3_d    = funct3_q;
      busy_d      = busy_q;

      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               // Latch the winning payload. From this point, changes made by
               // the requester are ignored.
               lat_we_d    = win_we;
               lat_id_d    = win;
               last_d      = win;
               a_d         = win ? addr1    : addr0;
               wd_d        = win ? wdata1   : wdata0;
               funct3_d    = win ? funct3_1 : funct3_0;
               mem_write_d = win_we;
               mem_read_d  = ~win_we;
               gnt0_d      = ~win;
               gnt1_d      = win;
               busy_d      = 1'b1;
               state_d     = ISSUE;
            end else begin
               busy_d      = 1'b0;
            end
         end

         ISSUE: begin
            if (!lat_we_q) begin
               // Memory read data is valid during this cycle. Capture it for
               // the port that owns the access.
               if (lat_id_q) begin
                  rdata1_d  = rd;
                  rvalid1_d = 1'b1;
               end else begin
                  rdata0_d  = rd;
                  rvalid0_d = 1'b1;
               end
               busy_d  = 1'b1;
               state_d = RESP;
            end else begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end

         RESP: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end

         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers. On reset, last = 1 so that port 0 wins the
   // first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         lat_we_q    <= 1'b0;
         lat_id_q    <= 1'b0;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         rvalid0_q   <= 1'b0;
         rvalid1_q   <= 1'b0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         a_q         <= '0;
         wd_q        <= '0;
         funct3_q    <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         lat_we_q    <= lat_we_d;
         lat_id_q    <= lat_id_d;
         gnt0_q      <= gnt0_d;
         gnt1_q      <= gnt1_d;
         rvalid0_q   <= rvalid0_d;
         rvalid1_q   <= rvalid1_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         a_q         <= a_d;
         wd_q        <= wd_d;
         funct3_q    <= funct3_d;
         busy_q      <= busy_d;
      end
   end

   assign gnt0     = gnt0_q;
   assign gnt1     = gnt1_q;
   assign rvalid0  = rvalid0_q;
   assign rvalid1  = rvalid1_q;
   assign rdata0   = rdata0_q;
   assign rdata1   = rdata1_q;
   assign MemRead  = mem_read_q;
   assign MemWrite = mem_write_q;
   assign a        = a_q;
   assign wd       = wd_q;
   assign Funct3   = funct3_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter, with a behavioural
// word memory connected to the memory side. The build macro
// DMEM_ARB_FIXED_PRIO_EN selects the expected grant order under contention.
module tb_dmem_arbiter;

   localparam int AW = 9;
   localparam int DW = 32;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic          req0, we0, gnt0, rvalid0;
   logic [AW-1:0] addr0;
   logic [DW-1:0] wdata0, rdata0;
   logic [2:0]    funct3_0;
   logic          req1, we1, gnt1, rvalid1;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata1, rdata1;
   logic [2:0]    funct3_1;
   logic          MemRead, MemWrite, busy;
   logic [AW-1:0] a;
   logic [DW-1:0] wd, rd;
   logic [2:0]    Funct3;

   dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .funct3_0(funct3_0),
      .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .funct3_1(funct3_1),
      .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
      .MemRead(MemRead), .MemWrite(MemWrite), .a(a), .wd(wd), .Funct3(Funct3),
      .rd(rd), .busy(busy)
   );

   function automatic logic [DW-1:0] init_word(input int i);
      if (i == 4) return 32'hDEADBEEF;
      return 32'hA500_0000 ^ (32'(i) * 32'h0101_0101);
   endfunction

   // Behavioural data memory: combinational read, write on the clock edge.
   logic [DW-1:0] mem [0:127];
   logic          mem_ready = 1'b0;
   assign rd = mem[a[8:2]];
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 128; i++) mem[i] <= init_word(i);
         mem_ready <= 1'b1;
      end else if (MemWrite) begin
         mem[a[8:2]] <= wd;
      end
   end

   // Bench-side expected memory contents.
   logic [DW-1:0] exp_mem [0:127];

   // scoreboard
   logic [DW-1:0] exp_q0[$];
   logic [DW-1:0] exp_q1[$];
   int            gnt_log[$];
   int            n_cmp = 0;
   int            n_err = 0;
   int            cyc = 0;
   int            rd_cycles = 0;
   int            wr_cycles = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: log grants, count memory strobes, and compare returned load data.
   always @(negedge clk) begin
      if (rst_n) begin
         if (gnt0) gnt_log.push_back(0);
         if (gnt1) gnt_log.push_back(1);
         if (gnt0 && gnt1) check("gnt_onehot", 32'(gnt1), 32'(!gnt0));
         if (MemRead) rd_cycles++;
         if (MemWrite) wr_cycles++;
         if (rvalid0) begin
            if (exp_q0.size() == 0) check("rvalid0_spurious", 32'(rvalid0), 32'd0);
            else check("rdata0", rdata0, exp_q0.pop_front());
         end
         if (rvalid1) begin
            if (exp_q1.size() == 0) check("rvalid1_spurious", 32'(rvalid1), 32'd0);
            else check("rdata1", rdata1, exp_q1.pop_front());
         end
      end
   end

   // driver tasks
   task automatic set_port(input int p, input logic r, input logic w,
                           input logic [AW-1:0] ad, input logic [DW-1:0] d);
      if (p == 0) begin
         req0 = r; we0 = w; addr0 = ad; wdata0 = d; funct3_0 = 3'b010;
      end else begin
         req1 = r; we1 = w; addr1 = ad; wdata1 = d; funct3_1 = 3'b010;
      end
   endtask

   task automatic wait_gnt(input int p, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if ((p == 0) ? gnt0 : gnt1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("gnt_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic push_exp(input int p, input logic [DW-1:0] v);
      if (p == 0) exp_q0.push_back(v);
      else        exp_q1.push_back(v);
   endtask

   // One uncontended access, with checks on latency, memory strobes and routing.
   task automatic single_access(input int p, input logic w, input logic [AW-1:0] ad,
                                input logic [DW-1:0] d);
      bit ok;
      int c0, rdc, wrc;
      @(negedge clk);
      set_port(p, 1'b1, w, ad, d);
      c0 = cyc; rdc = rd_cycles; wrc = wr_cycles;
      wait_gnt(p, 20, ok);
      if (ok) begin
         check("gnt_latency", 32'(cyc - c0), 32'd1);
         check("issue_a", 32'(a), 32'(ad));
         check("issue_memread", 32'(MemRead), 32'(!w));
         check("issue_memwrite", 32'(MemWrite), 32'(w));
         check("issue_funct3", 32'(Funct3), 32'd2);
         if (w) begin
            check("issue_wd", wd, d);
            exp_mem[ad[8:2]] = d;
         end else begin
            push_exp(p, exp_mem[ad[8:2]]);
         end
      end
      set_port(p, 1'b0, w, ad, d);
      @(negedge clk);
      check("rvalid_latency", 32'((p == 0) ? rvalid0 : rvalid1), 32'(!w));
      check("rvalid_other_port", 32'((p == 0) ? rvalid1 : rvalid0), 32'd0);
      check("memread_off_after_issue", 32'(MemRead | MemWrite), 32'd0);
      wait_idle();
      check("memread_cycles", 32'(rd_cycles - rdc), 32'(!w));
      check("memwrite_cycles", 32'(wr_cycles - wrc), 32'(w));
   endtask

   // A port that keeps its request up for n back-to-back loads.
   task automatic port_stream(input int p, input int n);
      bit ok;
      logic [AW-1:0] ad;
      for (int k = 0; k < n; k++) begin
         ad = 9'h100 + 9'(p * 64) + 9'(k * 4);
         set_port(p, 1'b1, 1'b0, ad, '0);
         wait_gnt(p, 60, ok);
         if (ok) begin
            check("stream_a", 32'(a), 32'(ad));
            push_exp(p, exp_mem[ad[8:2]]);
         end
      end
      set_port(p, 1'b0, 1'b0, '0, '0);
   endtask

   typedef struct {
      int            port;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } vec_t;

   vec_t vecs[12];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int exp_order;
      for (int i = 0; i < 128; i++) exp_mem[i] = init_word(i);

      // Vector table: port, we, addr, wdata. Loads compare against exp_mem.
      vecs[0] = '{0, 1'b0, 9'h010, 32'h0};
      vecs[1] = '{1, 1'b1, 9'h020, 32'h12345678};
      vecs[2] = '{0, 1'b0, 9'h020, 32'h0};
      vecs[3] = '{1, 1'b0, 9'h000, 32'h0};
      vecs[4] = '{0, 1'b1, 9'h1FC, 32'hFFFFFFFF};
      vecs[5] = '{1, 1'b0, 9'h1FC, 32'h0};
      vecs[6] = '{0, 1'b1, 9'h000, 32'h0};
      vecs[7] = '{0, 1'b0, 9'h000, 32'h0};
      for (int i = 8; i < 12; i++) begin
         vecs[i].port  = int'($urandom_range(0, 1));
         vecs[i].we    = 1'($urandom_range(0, 1));
         vecs[i].addr  = 9'($urandom_range(0, 127) * 4);
         vecs[i].wdata = $urandom;
      end

      set_port(0, 1'b0, 1'b0, '0, '0);
      set_port(1, 1'b0, 1'b0, '0, '0);

      // reset
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
      check("rst_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
      check("rst_mem_strobes", 32'({MemRead, MemWrite}), 32'd0);
      check("rst_a", 32'(a), 32'd0);
      check("rst_wd", wd, 32'd0);
      check("rst_funct3", 32'(Funct3), 32'd0);
      check("rst_rdata0", rdata0, 32'd0);
      check("rst_rdata1", rdata1, 32'd0);

      // table-driven single accesses
      for (int i = 0; i < 12; i++) begin
         single_access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      end

      // Change the payload after it has been latched: memory must still see 0x010.
      @(negedge clk);
      set_port(0, 1'b1, 1'b0, 9'h010, '0);
      wait_gnt(0, 20, ok);
      addr0 = 9'h030;
      #1;
      check("latched_addr", 32'(a), 32'h010);
      if (ok) push_exp(0, exp_mem[4]);
      @(negedge clk);
      req0 = 1'b0;
      wait_idle();
      check("latched_rdata0", rdata0, 32'hDEADBEEF);

      // Reset during the ISSUE cycle of a store: nothing may be written.
      @(negedge clk);
      set_port(1, 1'b1, 1'b1, 9'h040, 32'hCAFEF00D);
      wait_gnt(1, 20, ok);
      rst_n = 1'b0;
      #1;
      check("midrst_memwrite", 32'(MemWrite), 32'd0);
      check("midrst_gnt1", 32'(gnt1), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_a", 32'(a), 32'd0);
      check("midrst_wd", wd, 32'd0);
      check("midrst_rdata0", rdata0, 32'd0);
      set_port(1, 1'b0, 1'b0, '0, '0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("midrst_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
      rst_n = 1'b1;

      // Contention immediately after reset: port 0 must win the first tie.
      gnt_log.delete();
      @(negedge clk);
      fork
         port_stream(0, 4);
         port_stream(1, 4);
      join
      wait_idle();
      check("contend_gnt_count", 32'(gnt_log.size()), 32'd8);
      for (int k = 0; k < 8; k++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
         exp_order = (k < 4) ? 0 : 1;
`else
         exp_order = k % 2;
`endif
         if (k < gnt_log.size()) check("contend_order", 32'(gnt_log[k]), 32'(exp_order));
      end
      check("contend_rdata0_hold", rdata0, exp_mem[(9'h100 + 9'd12) >> 2]);
      check("contend_rdata1_hold", rdata1, exp_mem[(9'h140 + 9'd12) >> 2]);

      // The aborted store must not have reached memory.
      single_access(0, 1'b0, 9'h040, '0);

      repeat (3) @(negedge clk);
      check("exp_q0_drained", 32'(exp_q0.size()), 32'd0);
      check("exp_q1_drained", 32'(exp_q1.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
